pptx_arbiter: RTL
=================

# pptx_arbiter

Line-granular round-robin arbiter that lets up to four byte-stream sources share the single transmit side of the parallel port (`pport` tx_stb/tx_data/tx_busy). A source holds the port until it sends an end-of-line byte, hits a maximum burst length, or goes idle too long. Lines from different sources therefore never interleave on the Pi side. It sits between the line buffers and message generators on one side and `pport` on the other.

## Interface
- `NIN`, 2: number of requesters, 2..4.
- `LINE_MODE`, 1: when 1, an accepted 0x0a or 0x0d byte releases the grant.
- `MAXLEN`, 80: accepted bytes per grant before forced release, 1..255.
- `TIMEOUT`, 16: consecutive cycles of granted `i_stb` low before forced release, 0..255. A value of 0 disables the timeout.
- `i_clk`  in  1  system clock (the `s_clk` domain). One clock; reset is synchronous and active-high.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_stb`  in  NIN  per-source byte valid.
- `i_data`  in  8*NIN  per-source byte. Source k occupies bits [8k+7:8k].
- `o_busy`  out  NIN  per-source busy. Source k's byte is taken when `i_stb[k] && !o_busy[k]`.
- `o_tx_stb`  out  1  to `pport` tx_stb.
- `o_tx_data`  out  8  to `pport` tx_data.
- `i_tx_busy`  in  1  from `pport` tx_busy.
- `o_grant`  out  NIN  one-hot current owner. All zero when idle.
- `o_active`  out  1  a grant is held.

## Operation
- States: IDLE and GRANTED. Registers: `state`, `owner` (2 b), `last` (2 b), `bytecnt` (8 b), `idlecnt` (8 b).
- Transfer: a byte moves to `pport` when `o_tx_stb && !i_tx_busy`. That same cycle is the accept cycle for the owner.
- IDLE:
  - `o_tx_stb`=0 and `o_busy` is all ones.
  - If any `i_stb` bit is high, go to GRANTED next cycle.
  - `owner` becomes the first requesting index searching `last+1, last+2, …` modulo NIN.
  - `bytecnt` and `idlecnt` clear to 0.
- GRANTED (owner g):
  - `o_tx_stb = i_stb[g]` and `o_tx_data = i_data[8g+7:8g]`, both combinational.
  - `o_busy[g] = i_tx_busy`. All other `o_busy` bits stay 1.
- Counters in GRANTED:
  - `bytecnt` increments on each accept.
  - `idlecnt` increments on each cycle with `i_stb[g]`=0 and clears on any cycle with `i_stb[g]`=1.
- Release: go to IDLE next cycle and set `last` to g when any of these holds:
  - an accepted byte is 0x0a or 0x0d and `LINE_MODE`=1;
  - an accept makes `bytecnt` reach MAXLEN;
  - `TIMEOUT`≠0 and `idlecnt` reaches TIMEOUT−1 while `i_stb[g]`=0.
- If several release causes hit in the same cycle, release exactly once.
- The released source may be re-granted only if it is the sole requester.
- A byte with `i_stb` high while `i_tx_busy` is high is held off (busy) and is not counted.

## Timing
- Reset values: `state`=IDLE, `owner`=0, `last`=NIN−1 (so source 0 wins first), counters 0. Therefore `o_grant`=0, `o_active`=0, `o_tx_stb`=0, `o_busy` all ones.
- While `i_reset` is high, `o_tx_stb` is forced to 0 and `o_busy` to all ones combinationally. Reset during GRANTED aborts the grant; no byte is accepted in the reset cycle.
- Grant latency: a request seen in IDLE at cycle n produces `o_grant` and a pass-through at n+1. The first byte can be accepted at n+1.
- Release latency: the release condition at cycle n gives IDLE at n+1, so the earliest next grant is at n+2. There is a one-cycle bubble between owners.
- Pass-through (`i_stb`→`o_tx_stb`, `i_tx_busy`→`o_busy`) has zero latency. No data is registered; `pport` provides the output register.
- `bytecnt` saturates at MAXLEN; it never wraps.

## Structure
- Shared header `pptx_defs.vh`: `PP_NL`=8'h0a, `PP_CR`=8'h0d, and the state encodings IDLE=1'b0 and GRANTED=1'b1. The `pport` line logic uses the same codes.
- One sub-module, `rr_pick`:
  - purely combinational;
  - inputs: request vector (NIN) and `last`;
  - outputs: `any` and `index`.
- The FSM, counters and output mux stay in `pptx_arbiter`.

## Test plan
- **Single source:** source 0 streams "HI\n" with `i_tx_busy`=0 from reset → `o_grant`=01 at cycle 1. Bytes 0x48, 0x49, 0x0a appear on `o_tx_data` at cycles 1–3. IDLE at cycle 4, `last`=0.
- **Round-robin:** both sources request continuously, each sending "A\n" (source 0) and "B\n" (source 1) → grant order 0,1,0,1. Each line is contiguous, with exactly one bubble cycle between grants.
- **MAXLEN:** MAXLEN=4, source 1 sends 6 non-newline bytes → release after the 4th accept. Source 0, if requesting, is granted next. Source 1's 5th byte waits with `o_busy[1]`=1.
- **Backpressure:** `i_tx_busy` high for 3 cycles mid-line → no accepts, `bytecnt` frozen, `o_busy[g]`=1. The resumed byte is accepted without loss or duplication.
- **Timeout and reset:**
  - TIMEOUT=4, owner drops `i_stb` after one byte → IDLE 4 cycles after the drop.
  - Assert `i_reset` mid-grant with a byte pending → `o_tx_stb`=0 that cycle, IDLE next, and source 0 has priority again.

Source files
------------

// File: rtl/pptx_arbiter_pkg.sv
// rtl/pptx_arbiter_pkg.sv - shared codes and types for the pport transmit arbiter
//
// Purpose: line-terminator byte codes (identical to the pport line logic),
//          arbiter FSM state encoding and a small end-of-line helper.
// Ports:   none (package).
package pptx_arbiter_pkg;

  localparam logic [7:0] PP_NL = 8'h0a;
  localparam logic [7:0] PP_CR = 8'h0d;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } pptx_state_t;

  function automatic logic is_eol(input logic [7:0] b);
    return (b == PP_NL) || (b == PP_CR);
  endfunction

endpackage

// File: rtl/pptx_arbiter_rr_pick.sv
// rtl/pptx_arbiter_rr_pick.sv - combinational round-robin requester pick
//
// Purpose: choose the first requesting index searching last+1, last+2, ...
//          modulo NIN, so the previous owner is considered last.
// Ports:
//   req    in  NIN  request vector, one bit per source
//   last   in  2    index of the most recently released owner
//   any    out 1    at least one request is present
//   index  out 2    winning source index (equals last when nothing requests)
module rr_pick
  import pptx_arbiter_pkg::*;
#(
  parameter int NIN = 2
) (
  input  logic [NIN-1:0] req,
  input  logic [1:0]     last,
  output logic           any,
  output logic [1:0]     index
);

  // Walk offsets from farthest to nearest so the nearest requester,
  // assigned last, wins.
  always_comb begin
    any   = |req;
    index = last;
    for (int off = NIN; off >= 1; off--) begin
      for (int j = 0; j < NIN; j++) begin
        if (req[j] && (((int'(last) + off) % NIN) == j)) begin
          index = 2'(j);
        end
      end
    end
  end

endmodule

// File: rtl/pptx_arbiter.sv
// rtl/pptx_arbiter.sv - line-granular round-robin arbiter in front of pport tx
//
// Purpose: lets up to four byte-stream sources share the pport transmit side.
//          A source keeps the port until it sends an end-of-line byte, reaches
//          MAXLEN accepted bytes, or leaves its strobe low for TIMEOUT cycles,
//          so lines from different sources never interleave.
// Ports:
//   i_clk      in  1      system clock (s_clk domain)
//   i_reset    in  1      synchronous, active-high reset
//   i_stb      in  NIN    per-source byte valid
//   i_data     in  8*NIN  per-source byte, source k at [8k+7:8k]
//   o_busy     out NIN    per-source busy; byte taken when i_stb[k] && !o_busy[k]
//   o_tx_stb   out 1      to pport tx_stb
//   o_tx_data  out 8      to pport tx_data
//   i_tx_busy  in  1      from pport tx_busy
//   o_grant    out NIN    one-hot current owner, zero when idle
//   o_active   out 1      a grant is held
module pptx_arbiter
  import pptx_arbiter_pkg::*;
#(
  parameter int NIN       = 2,
  parameter bit LINE_MODE = 1'b1,
  parameter int MAXLEN    = 80,
  parameter int TIMEOUT   = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NIN-1:0]   i_stb,
  input  logic [8*NIN-1:0] i_data,
  output logic [NIN-1:0]   o_busy,
  output logic             o_tx_stb,
  output logic [7:0]       o_tx_data,
  input  logic             i_tx_busy,
  output logic [NIN-1:0]   o_grant,
  output logic             o_active
);

  localparam logic [1:0] LAST_RST = 2'(NIN - 1);
  localparam logic [8:0] MAXLEN9  = 9'(MAXLEN);
  // Only meaningful when TIMEOUT != 0; the release term is gated on that.
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  pptx_state_t state;
  logic [1:0]  owner;
  logic [1:0]  last;
  logic [7:0]  bytecnt;
  logic [7:0]  idlecnt;

  logic        pick_any;
  logic [1:0]  pick_index;

  logic        stb_g;
  logic [7:0]  data_g;
  logic        granted;
  logic        accept;
  logic        eol_hit;
  logic        max_hit;
  logic        to_hit;
  logic        release_now;

  rr_pick #(
    .NIN (NIN)
  ) u_rr_pick (
    .req   (i_stb),
    .last  (last),
    .any   (pick_any),
    .index (pick_index)
  );

  // Owner's strobe and byte.
  always_comb begin
    stb_g  = 1'b0;
    data_g = 8'h00;
    for (int k = 0; k < NIN; k++) begin
      if (owner == 2'(k)) begin
        stb_g  = i_stb[k];
        data_g = i_data[8*k +: 8];
      end
    end
  end

  // Reset overrides the pass-through so no byte can move in the reset cycle.
  assign granted   = (state == ST_GRANTED) && !i_reset;
  assign o_tx_stb  = granted && stb_g;
  assign o_tx_data = data_g;
  assign o_active  = (state == ST_GRANTED);
  assign accept    = o_tx_stb && !i_tx_busy;

  always_comb begin
    o_busy  = '1;
    o_grant = '0;
    for (int k = 0; k < NIN; k++) begin
      if ((state == ST_GRANTED) && (owner == 2'(k))) begin
        o_grant[k] = 1'b1;
        if (granted) begin
          o_busy[k] = i_tx_busy;
        end
      end
    end
  end

  // Release causes are OR-ed so simultaneous causes release only once.
  assign eol_hit     = LINE_MODE && accept && is_eol(data_g);
  assign max_hit     = accept && (({1'b0, bytecnt} + 9'd1) >= MAXLEN9);
  assign to_hit      = (TIMEOUT != 0) && !stb_g && (idlecnt == TO_LAST);
  assign release_now = eol_hit || max_hit || to_hit;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      owner   <= 2'd0;
      last    <= LAST_RST;
      bytecnt <= 8'd0;
      idlecnt <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          bytecnt <= 8'd0;
          idlecnt <= 8'd0;
          if (pick_any) begin
            state <= ST_GRANTED;
            owner <= pick_index;
          end
        end
        ST_GRANTED: begin
          if (accept && (({1'b0, bytecnt}) < MAXLEN9)) begin
            bytecnt <= bytecnt + 8'd1;
          end
          if (stb_g) begin
            idlecnt <= 8'd0;
          end else if (idlecnt != 8'hff) begin
            idlecnt <= idlecnt + 8'd1;
          end
          if (release_now) begin
            state <= ST_IDLE;
            last  <= owner;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
